// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg -- shared types and default parameters for the APB master controller.
// Optional feature macro: APB_TIMEOUT_EN (ACCESS-phase wait timeout, see apb_master_ctrl).
package apb_ctrl_pkg;

   // Transfer phases of the APB protocol as seen by the master
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int DEF_ADDR_WIDTH     = 32;
   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_NUM_SLAVES     = 4;
   localparam int DEF_SEL_LSB        = 12;
   localparam int DEF_TIMEOUT_CYCLES = 16;

   // Number of address bits needed to index num_slaves select lines
   function automatic int sel_width(input int num_slaves);
      return (num_slaves > 1) ? $clog2(num_slaves) : 1;
   endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if -- APB bus bundle between the master controller and the slave fabric.
// Optional feature macro: APB_TIMEOUT_EN (not used in this file).
interface apb_master_ctrl_if
   import apb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_SLAVES = DEF_NUM_SLAVES
);

   logic [ADDR_WIDTH-1:0]   PADDR;
   logic [NUM_SLAVES-1:0]   PSEL;
   logic                    PENABLE;
   logic                    PWRITE;
   logic [DATA_WIDTH-1:0]   PWDATA;
   logic [DATA_WIDTH/8-1:0] PSTRB;
   logic [DATA_WIDTH-1:0]   PRDATA;
   logic                    PREADY;
   logic                    PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_addr_decode.sv
// apb_addr_decode -- turns a request address into a one-hot slave select and a decode error.
// The slave index lives at addr[SEL_LSB +: log2(NUM_SLAVES)]; any set bit above it is unmapped.
// Optional feature macro: APB_TIMEOUT_EN (not used in this file).
module apb_addr_decode
   import apb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_SLAVES = DEF_NUM_SLAVES,
   parameter int SEL_LSB    = DEF_SEL_LSB
)
(
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  dec_err
);

   localparam int SEL_W   = sel_width(NUM_SLAVES);
   localparam int TOP_LSB = SEL_LSB + SEL_W;

   logic [SEL_W-1:0] slave_idx;

   assign slave_idx = addr[SEL_LSB +: SEL_W];

   generate
      if (TOP_LSB < ADDR_WIDTH) begin : g_upper
         assign dec_err = |addr[ADDR_WIDTH-1:TOP_LSB];
      end else begin : g_no_upper
         assign dec_err = 1'b0;
      end

      if (SEL_LSB > 0) begin : g_low
         logic unused_low_bits;
         assign unused_low_bits = ^addr[SEL_LSB-1:0];
      end
   endgenerate

   // One-hot select for the indexed slave, suppressed when the address is unmapped
   always_comb begin
      sel = '0;
      if (!dec_err) begin
         sel[slave_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl -- bridge-request to APB master controller (IDLE / SETUP / ACCESS).
// Captures one request at a time, drives the APB bus from registers and reports completion
// with a one-cycle apb_done pulse plus err_flag.
// Optional feature macro: APB_TIMEOUT_EN -- abort ACCESS after TIMEOUT_CYCLES not-ready cycles.
module apb_master_ctrl
   import apb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int NUM_SLAVES     = DEF_NUM_SLAVES,
   parameter int SEL_LSB        = DEF_SEL_LSB,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)
(
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    transfer,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   apb_waddr,
   input  logic [ADDR_WIDTH-1:0]   apb_raddr,
   input  logic [DATA_WIDTH-1:0]   apb_wdata,
   input  logic [DATA_WIDTH/8-1:0] apb_wstrb,
   output logic [DATA_WIDTH-1:0]   apb_rdata,
   output logic                    apb_done,
   output logic                    err_flag,
   apb_master_ctrl_if.master       apb
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   apb_state_e              state;
   logic                    prio_write;
   logic [NUM_SLAVES-1:0]   psel_q;
   logic                    penable_q;
   logic                    pwrite_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [STRB_WIDTH-1:0]   pstrb_q;

   logic                    capture_fire;
   logic                    collision;
   logic                    grant_write;
   logic [ADDR_WIDTH-1:0]   req_addr;
   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_err;

`ifdef APB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TO_W-1:0] wait_cnt;
   logic            timeout_hit;
   assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign apb.PSTRB   = pstrb_q;

   // A request is only taken while idle and not in the cycle that reports the previous one
   assign capture_fire = (state == IDLE) && !apb_done && transfer && (read || write);
   assign collision    = read && write;
   assign req_addr     = grant_write ? apb_waddr : apb_raddr;

   // Direction grant: a lone requester always wins, a collision follows the priority bit
   always_comb begin
      grant_write = write;
      if (collision) begin
         grant_write = prio_write;
      end
   end

   apb_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_LSB    (SEL_LSB)
   ) u_decode (
      .addr    (req_addr),
      .sel     (dec_sel),
      .dec_err (dec_err)
   );

   // Transfer FSM with every bus and status output registered
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state      <= IDLE;
         prio_write <= 1'b1;
         psel_q     <= '0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         pstrb_q    <= '0;
         apb_rdata  <= '0;
         apb_done   <= 1'b0;
         err_flag   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         apb_done <= 1'b0;
         err_flag <= 1'b0;
         case (state)
            IDLE: begin
               if (capture_fire) begin
                  if (collision) begin
                     prio_write <= ~prio_write;
                  end
                  if (dec_err) begin
                     apb_done <= 1'b1;
                     err_flag <= 1'b1;
                     if (!grant_write) begin
                        apb_rdata <= '0;
                     end
                  end else begin
                     state     <= SETUP;
                     psel_q    <= dec_sel;
                     penable_q <= 1'b0;
                     paddr_q   <= req_addr;
                     pwrite_q  <= grant_write;
                     pwdata_q  <= apb_wdata;
                     pstrb_q   <= grant_write ? apb_wstrb : '0;
                  end
               end
            end
            SETUP: begin
               state     <= ACCESS;
               penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
               wait_cnt  <= '0;
`endif
            end
            ACCESS: begin
               if (apb.PREADY) begin
                  state     <= IDLE;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  apb_done  <= 1'b1;
                  err_flag  <= apb.PSLVERR;
                  if (!pwrite_q) begin
                     apb_rdata <= apb.PSLVERR ? '0 : apb.PRDATA;
                  end
               end
`ifdef APB_TIMEOUT_EN
               else if (timeout_hit) begin
                  state     <= IDLE;
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  apb_done  <= 1'b1;
                  err_flag  <= 1'b1;
                  if (!pwrite_q) begin
                     apb_rdata <= '0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            default: begin
               state     <= IDLE;
               psel_q    <= '0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl -- self-checking bench for apb_master_ctrl with a transaction-level model.
// Optional feature macro: APB_TIMEOUT_EN (enables the timeout scenario).
module tb_apb_master_ctrl;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int NS       = 4;
   localparam int SEL_LSB  = 12;
   localparam int TIMEOUT  = 16;
   localparam int BUDGET   = 40;
   localparam int SEL_BITS = 2;

   logic          ACLK;
   logic          ARESETn;
   logic          transfer;
   logic          read;
   logic          write;
   logic [AW-1:0] apb_waddr;
   logic [AW-1:0] apb_raddr;
   logic [DW-1:0] apb_wdata;
   logic [3:0]    apb_wstrb;
   logic [DW-1:0] apb_rdata;
   logic          apb_done;
   logic          err_flag;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state: collision priority and the last read result
   logic          m_prio_write;
   logic [DW-1:0] m_rdata;
   logic          obs_pwrite;

   apb_master_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

   apb_master_ctrl #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .NUM_SLAVES     (NS),
      .SEL_LSB        (SEL_LSB),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .transfer  (transfer),
      .read      (read),
      .write     (write),
      .apb_waddr (apb_waddr),
      .apb_raddr (apb_raddr),
      .apb_wdata (apb_wdata),
      .apb_wstrb (apb_wstrb),
      .apb_rdata (apb_rdata),
      .apb_done  (apb_done),
      .err_flag  (err_flag),
      .apb       (bus.master)
   );

   // Free-running 100 MHz clock
   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One full request: drive it, play the slave, and compare against the model
   task automatic applyStimulus(input string name, input logic rd, input logic wr,
                                input logic [AW-1:0] waddr, input logic [AW-1:0] raddr,
                                input logic [DW-1:0] wdata, input logic [3:0] wstrb,
                                input int waits, input logic [DW-1:0] prdata,
                                input logic slverr);
      logic          g_write;
      logic [AW-1:0] addr;
      logic          e_dec_err;
      logic          e_timeout;
      logic          e_err;
      logic [3:0]    e_sel;
      int            e_lat;
      int            done_at;

      if (rd && wr) begin
         g_write      = m_prio_write;
         m_prio_write = !m_prio_write;
      end else begin
         g_write = wr;
      end
      addr      = g_write ? waddr : raddr;
      e_dec_err = (addr >> (SEL_LSB + SEL_BITS)) != 0;
      e_sel     = 4'(1 << ((addr >> SEL_LSB) % NS));
`ifdef APB_TIMEOUT_EN
      e_timeout = !e_dec_err && (waits >= TIMEOUT);
`else
      e_timeout = 1'b0;
`endif
      e_err = e_dec_err || e_timeout || slverr;
      if (e_dec_err)      e_lat = 1;
      else if (e_timeout) e_lat = 2 + TIMEOUT;
      else                e_lat = 3 + waits;
      if (!g_write) m_rdata = e_err ? '0 : prdata;

      @(negedge ACLK);
      transfer    = 1'b1;
      read        = rd;
      write       = wr;
      apb_waddr   = waddr;
      apb_raddr   = raddr;
      apb_wdata   = wdata;
      apb_wstrb   = wstrb;
      bus.PREADY  = 1'b0;
      bus.PRDATA  = prdata;
      bus.PSLVERR = slverr;
      @(posedge ACLK);
      #1;
      transfer  = 1'b0;
      read      = 1'($urandom);
      write     = 1'($urandom);
      apb_waddr = $urandom;
      apb_raddr = $urandom;
      apb_wdata = $urandom;

      done_at = 0;
      for (int c = 1; c <= BUDGET && done_at == 0; c++) begin
         @(negedge ACLK);
         if (apb_done) done_at = c;
         if (c == 1) begin
            obs_pwrite = bus.PWRITE;
            if (e_dec_err) begin
               checkOutput($sformatf("%s_psel_none", name), bus.PSEL, 0);
            end else begin
               checkOutput($sformatf("%s_setup_psel", name), bus.PSEL, e_sel);
               checkOutput($sformatf("%s_setup_pen", name), bus.PENABLE, 0);
               checkOutput($sformatf("%s_paddr", name), bus.PADDR, addr);
               checkOutput($sformatf("%s_pwrite", name), bus.PWRITE, g_write);
               checkOutput($sformatf("%s_pstrb", name), bus.PSTRB, g_write ? wstrb : 4'h0);
               if (g_write) checkOutput($sformatf("%s_pwdata", name), bus.PWDATA, wdata);
            end
         end
         if (c == 2 && !e_dec_err) begin
            checkOutput($sformatf("%s_access_pen", name), bus.PENABLE, 1);
            checkOutput($sformatf("%s_access_psel", name), bus.PSEL, e_sel);
         end
         if (!e_dec_err) bus.PREADY = (c >= 2) && (c - 2 == waits);
      end
      bus.PREADY = 1'b0;

      checkOutput($sformatf("%s_latency", name), done_at, e_lat);
      if (done_at != 0) begin
         checkOutput($sformatf("%s_err", name), err_flag, e_err);
         checkOutput($sformatf("%s_rdata", name), apb_rdata, m_rdata);
         checkOutput($sformatf("%s_done_psel", name), bus.PSEL, 0);
         checkOutput($sformatf("%s_done_pen", name), bus.PENABLE, 0);
         @(negedge ACLK);
         checkOutput($sformatf("%s_pulse", name), {apb_done, err_flag}, 2'b00);
      end
   endtask

   // Start a read that stalls in ACCESS, then pull reset mid-transfer
   task automatic applyResetAbort();
      logic done_seen;
      @(negedge ACLK);
      transfer    = 1'b1;
      read        = 1'b1;
      write       = 1'b0;
      apb_raddr   = 32'h0000_2008;
      bus.PREADY  = 1'b0;
      bus.PRDATA  = 32'h1234_5678;
      bus.PSLVERR = 1'b0;
      @(posedge ACLK);
      #1;
      transfer = 1'b0;
      read     = 1'b0;
      @(negedge ACLK);
      @(negedge ACLK);
      checkOutput("rst_in_access", {bus.PSEL, bus.PENABLE}, {4'b0100, 1'b1});
      #2;
      ARESETn = 1'b0;
      #1;
      checkOutput("rst_psel_now", bus.PSEL, 0);
      checkOutput("rst_pen_now", bus.PENABLE, 0);
      checkOutput("rst_paddr_now", bus.PADDR, 0);
      checkOutput("rst_rdata_now", apb_rdata, 0);
      m_prio_write = 1'b1;
      m_rdata      = '0;
      @(negedge ACLK);
      ARESETn   = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         done_seen = done_seen | apb_done;
      end
      checkOutput("rst_no_done", done_seen, 0);
   endtask

   initial begin
      logic          rd;
      logic          wr;
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;

      ARESETn      = 1'b0;
      transfer     = 1'b0;
      read         = 1'b0;
      write        = 1'b0;
      apb_waddr    = '0;
      apb_raddr    = '0;
      apb_wdata    = '0;
      apb_wstrb    = '0;
      bus.PRDATA   = '0;
      bus.PREADY   = 1'b0;
      bus.PSLVERR  = 1'b0;
      m_prio_write = 1'b1;
      m_rdata      = '0;
      obs_pwrite   = 1'b0;

      repeat (3) @(negedge ACLK);
      checkOutput("reset_bus", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB}, 0);
      checkOutput("reset_paddr", bus.PADDR, 0);
      checkOutput("reset_pwdata", bus.PWDATA, 0);
      checkOutput("reset_status", {apb_rdata, apb_done, err_flag}, 0);
      ARESETn = 1'b1;
      @(negedge ACLK);

      applyStimulus("wr_1000", 1'b0, 1'b1, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 4'hF,
                    0, 32'h0, 1'b0);
      checkOutput("wr_1000_psel_const", bus.PSEL, 0);
      applyStimulus("rd_3004", 1'b1, 1'b0, 32'h0, 32'h0000_3004, 32'h0, 4'h0,
                    2, 32'hCAFE_F00D, 1'b0);
      checkOutput("rd_3004_rdata_const", apb_rdata, 32'hCAFE_F00D);

      applyStimulus("coll_a", 1'b1, 1'b1, 32'h0000_0010, 32'h0000_2020, 32'h1111_2222, 4'h3,
                    0, 32'hAAAA_5555, 1'b0);
      checkOutput("coll_a_is_write", obs_pwrite, 1);
      applyStimulus("coll_b", 1'b1, 1'b1, 32'h0000_0014, 32'h0000_2024, 32'h3333_4444, 4'hC,
                    1, 32'h5555_AAAA, 1'b0);
      checkOutput("coll_b_is_read", obs_pwrite, 0);

      applyStimulus("wr_dec_err", 1'b0, 1'b1, 32'h0001_0000, 32'h0, 32'h0BAD_0BAD, 4'hF,
                    0, 32'h0, 1'b0);
      applyStimulus("rd_slverr", 1'b1, 1'b0, 32'h0, 32'h0000_1008, 32'h0, 4'h0,
                    1, 32'hFFFF_FFFF, 1'b1);
      checkOutput("rd_slverr_rdata_const", apb_rdata, 0);

      applyStimulus("coll_c", 1'b1, 1'b1, 32'h0000_3000, 32'h0000_1000, 32'h7777_8888, 4'hF,
                    0, 32'h0, 1'b0);
      applyResetAbort();
      applyStimulus("coll_after_rst", 1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 32'h9999_0000,
                    4'h5, 0, 32'h0, 1'b0);
      checkOutput("coll_after_rst_write", obs_pwrite, 1);

`ifdef APB_TIMEOUT_EN
      applyStimulus("timeout_rd", 1'b1, 1'b0, 32'h0, 32'h0000_3010, 32'h0, 4'h0,
                    1000, 32'h1357_9BDF, 1'b0);
`endif

      for (int t = 0; t < 40; t++) begin
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (!rd && !wr) wr = 1'b1;
         wa = $urandom & 32'h0000_3FFF;
         ra = $urandom & 32'h0000_3FFF;
         if ($urandom_range(0, 7) == 0) wa = wa | (32'h1 << $urandom_range(14, 31));
         if ($urandom_range(0, 7) == 0) ra = ra | (32'h1 << $urandom_range(14, 31));
         applyStimulus($sformatf("rnd%0d", t), rd, wr, wa, ra, $urandom, 4'($urandom),
                       $urandom_range(0, 4), $urandom, $urandom_range(0, 7) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of address buses.
REQ-002 Parameter DATA_WIDTH, 32, width of data buses.
REQ-003 Parameter NUM_SLAVES, 4, number of PSEL lines; power of two, 2 to 16.
REQ-004 Parameter SEL_LSB, 12, lowest address bit of slave index field.
REQ-005 Parameter TIMEOUT_CYCLES, 16, ACCESS wait limit, used only when APB_TIMEOUT_EN is defined.
REQ-006 Clock and reset SHALL be exactly: one clock ACLK; reset ARESETn is asynchronous and active-low.
REQ-007 Ports SHALL be:
- ACLK  in  1  clock.
- ARESETn  in  1  async active-low reset.
- transfer  in  1  request qualifier from bridge.
- read  in  1  read request.
- write  in  1  write request.
- apb_waddr  in  ADDR_WIDTH  write address.
- apb_raddr  in  ADDR_WIDTH  read address.
- apb_wdata  in  DATA_WIDTH  write data.
- apb_wstrb  in  DATA_WIDTH/8  write strobes.
- apb_rdata  out  DATA_WIDTH  read result.
- apb_done  out  1  one-cycle completion pulse.
- err_flag  out  1  error, valid with apb_done.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  DATA_WIDTH/8  APB strobes; 0 on reads.
- PRDATA  in  DATA_WIDTH  selected slave read data.
- PREADY  in  1  selected slave ready.
- PSLVERR  in  1  selected slave error.

Function
REQ-008 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-009 In IDLE with apb_done low and transfer high and read or write high, request SHALL be captured (address, data, strobe, direction) at the edge; all request inputs SHALL be ignored otherwise.
REQ-010 When read and write are both high at capture, direction SHALL follow a priority bit (reset = write), toggled after every such collision; a single requester SHALL be granted regardless of priority.
REQ-011 Slave index SHALL be addr[SEL_LSB +: log2(NUM_SLAVES)]; any set bit above that field SHALL be a decode error.
REQ-012 Decode error: no PSEL asserted, IDLE->IDLE, apb_done=1 and err_flag=1 on the cycle after capture.
REQ-013 IDLE->SETUP on valid capture: PSEL one-hot, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from captured registers.
REQ-014 SETUP->ACCESS unconditionally: PENABLE=1; all APB outputs stable.
REQ-015 ACCESS->IDLE at the edge where PREADY=1; PSEL and PENABLE deasserted in the next cycle; otherwise remain in ACCESS.
REQ-016 apb_done SHALL pulse exactly one cycle, in the first IDLE cycle after completion; zero-wait-state latency = 3 cycles from capture edge to apb_done.
REQ-017 err_flag SHALL equal PSLVERR sampled with PREADY (or decode/timeout error) and be 0 whenever apb_done is 0.
REQ-018 apb_rdata SHALL load PRDATA on successful read completion, 0 on errored read, and hold across writes.

Reset
REQ-019 ARESETn low SHALL immediately force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, apb_rdata=0, apb_done=0, err_flag=0, priority=write, even mid-transfer; aborted transfer reports no completion.

Configuration
REQ-020 With APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY=0; on reaching TIMEOUT_CYCLES, PSEL/PENABLE SHALL drop, FSM -> IDLE, apb_done=1 with err_flag=1; without the macro, ACCESS SHALL wait indefinitely and no counter exists.

Structure
REQ-021 Package apb_ctrl_pkg SHALL hold the state enum and default parameter constants.
REQ-022 Address decode SHALL be sub-module apb_addr_decode (address in; one-hot select and decode-error out).

Verification
REQ-023 Write 0xDEADBEEF to 0x1000, PREADY=1 -> PSEL=4'b0010, PWRITE=1, PSTRB=4'hF, apb_done 3 cycles after capture, err_flag=0.
REQ-024 Read 0x3004, PREADY low 2 ACCESS cycles, PRDATA=0xCAFEF00D -> apb_done after 5 cycles, apb_rdata=0xCAFEF00D.
REQ-025 read and write both high twice in succession -> write granted first, read second.
REQ-026 Write to 0x10000 -> no PSEL, apb_done with err_flag=1; PSLVERR=1 on read -> err_flag=1, apb_rdata=0.
REQ-027 APB_TIMEOUT_EN, PREADY held 0 -> abort after 16 ACCESS cycles with err_flag=1; ARESETn low during ACCESS -> PSEL=0 immediately, no apb_done.
